// File: rtl/vmem_dma_pkg.sv
// Shared definitions for the vmem_dma copy engine: register map, control and
// status bit positions, and copy FSM state encodings.
package vmem_dma_pkg;

   localparam logic [2:0] REG_SRC_LO = 3'd0;
   localparam logic [2:0] REG_SRC_HI = 3'd1;
   localparam logic [2:0] REG_DST_LO = 3'd2;
   localparam logic [2:0] REG_DST_HI = 3'd3;
   localparam logic [2:0] REG_LEN_LO = 3'd4;
   localparam logic [2:0] REG_LEN_HI = 3'd5;
   localparam logic [2:0] REG_CTRL   = 3'd6;
   localparam logic [2:0] REG_STATUS = 3'd7;

   localparam int CTRL_START  = 0;
   localparam int CTRL_IRQ_EN = 1;
   localparam int STAT_BUSY   = 0;
   localparam int STAT_DONE   = 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD      = 2'd1,
      ST_RD_WAIT = 2'd2,
      ST_WR      = 2'd3
   } state_t;

endpackage

// File: rtl/vmem_dma.sv
// Block copy engine that steals idle CPU data-bus cycles; the CPU always wins
// the bus and the DMA simply holds its request until a cycle is free.
module vmem_dma
   import vmem_dma_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8,
   parameter int LEN_W  = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_we,
   input  logic              cpu_re,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   output logic              bus_we,
   output logic              bus_re,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic [2:0]        cfg_addr,
   input  logic [DATA_W-1:0] cfg_wdata,
   input  logic              cfg_we,
   input  logic              cfg_re,
   output logic [DATA_W-1:0] cfg_rdata,
   output logic              irq,
   input  logic              irq_clr
);

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

   state_t              state_r, state_nxt_s;
   logic [ADDR_W-1:0]   src_r, dst_r, w_src_r, w_dst_r;
   logic [LEN_W-1:0]    len_r, w_cnt_r;
   logic [DATA_W-1:0]   buf_r, cfg_rdata_r, rd_mux_s;
   logic                irq_en_r, done_r;
   logic                grant_cpu_s, busy_s, start_s, start_go_s, start_zero_s;
   logic                wr_last_s, done_set_s, done_clr_s;
   logic                dma_re_s, dma_we_s;
   logic [ADDR_W-1:0]   dma_addr_s;
   logic [DATA_W-1:0]   dma_wdata_s;

   assign grant_cpu_s  = cpu_we | cpu_re;
   assign busy_s       = (state_r != ST_IDLE);
   assign start_s      = cfg_we && (cfg_addr == REG_CTRL) && cfg_wdata[CTRL_START];
   assign start_go_s   = start_s && !busy_s && (len_r != '0);
   assign start_zero_s = start_s && !busy_s && (len_r == '0);
   assign wr_last_s    = (state_r == ST_WR) && !grant_cpu_s && (w_cnt_r == LEN_ONE);
   assign done_set_s   = start_zero_s | wr_last_s;
   assign done_clr_s   = irq_clr | (cfg_we && (cfg_addr == REG_STATUS) && cfg_wdata[STAT_DONE]);

   assign cpu_rdata = bus_rdata;
   assign cfg_rdata = cfg_rdata_r;
   assign irq       = done_r & irq_en_r;

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic; RD and WR hold while the CPU owns the bus
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE:    if (start_go_s) state_nxt_s = ST_RD; else state_nxt_s = ST_IDLE;
         ST_RD:      if (grant_cpu_s) state_nxt_s = ST_RD; else state_nxt_s = ST_RD_WAIT;
         ST_RD_WAIT: state_nxt_s = ST_WR;
         ST_WR: begin
            if (grant_cpu_s)                state_nxt_s = ST_WR;
            else if (w_cnt_r == LEN_ONE)    state_nxt_s = ST_IDLE;
            else                            state_nxt_s = ST_RD;
         end
         default:    state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM outputs: the DMA's bus request for the current state
   always_comb begin
      dma_re_s    = 1'b0;
      dma_we_s    = 1'b0;
      dma_addr_s  = '0;
      dma_wdata_s = '0;
      case (state_r)
         ST_RD: begin
            dma_re_s   = 1'b1;
            dma_addr_s = w_src_r;
         end
         ST_WR: begin
            dma_we_s    = 1'b1;
            dma_addr_s  = w_dst_r;
            dma_wdata_s = buf_r;
         end
         default: begin
            dma_re_s = 1'b0;
         end
      endcase
   end

   // Bus arbiter: CPU strobes pass straight through whenever present
   always_comb begin
      if (grant_cpu_s) begin
         bus_re    = cpu_re;
         bus_we    = cpu_we;
         bus_addr  = cpu_addr;
         bus_wdata = cpu_wdata;
      end else begin
         bus_re    = dma_re_s;
         bus_we    = dma_we_s;
         bus_addr  = dma_addr_s;
         bus_wdata = dma_wdata_s;
      end
   end

   // Working copy pointers, byte counter and data buffer
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         w_src_r <= '0;
         w_dst_r <= '0;
         w_cnt_r <= '0;
         buf_r   <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_go_s) begin
                  w_src_r <= src_r;
                  w_dst_r <= dst_r;
                  w_cnt_r <= len_r;
               end
            end
            ST_RD_WAIT: buf_r <= bus_rdata;
            ST_WR: begin
               if (!grant_cpu_s) begin
                  w_src_r <= w_src_r + ADDR_ONE;
                  w_dst_r <= w_dst_r + ADDR_ONE;
                  w_cnt_r <= w_cnt_r - LEN_ONE;
               end
            end
            default: ;
         endcase
      end
   end

   // Register readback selection
   always_comb begin
      rd_mux_s = '0;
      case (cfg_addr)
         REG_SRC_LO: rd_mux_s = src_r[DATA_W-1:0];
         REG_SRC_HI: rd_mux_s = src_r[ADDR_W-1:DATA_W];
         REG_DST_LO: rd_mux_s = dst_r[DATA_W-1:0];
         REG_DST_HI: rd_mux_s = dst_r[ADDR_W-1:DATA_W];
         REG_LEN_LO: rd_mux_s = len_r[DATA_W-1:0];
         REG_LEN_HI: rd_mux_s = {{(2*DATA_W-LEN_W){1'b0}}, len_r[LEN_W-1:DATA_W]};
         REG_CTRL:   rd_mux_s[CTRL_IRQ_EN] = irq_en_r;
         REG_STATUS: begin
            rd_mux_s[STAT_BUSY] = busy_s;
            rd_mux_s[STAT_DONE] = done_r;
         end
         default:    rd_mux_s = '0;
      endcase
   end

   // Config registers, DONE flag and registered readback; parameters freeze while busy
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         src_r       <= '0;
         dst_r       <= '0;
         len_r       <= '0;
         irq_en_r    <= 1'b0;
         done_r      <= 1'b0;
         cfg_rdata_r <= '0;
      end else begin
         if (cfg_we && !busy_s) begin
            case (cfg_addr)
               REG_SRC_LO: src_r[DATA_W-1:0]      <= cfg_wdata;
               REG_SRC_HI: src_r[ADDR_W-1:DATA_W] <= cfg_wdata;
               REG_DST_LO: dst_r[DATA_W-1:0]      <= cfg_wdata;
               REG_DST_HI: dst_r[ADDR_W-1:DATA_W] <= cfg_wdata;
               REG_LEN_LO: len_r[DATA_W-1:0]      <= cfg_wdata;
               REG_LEN_HI: len_r[LEN_W-1:DATA_W]  <= cfg_wdata[LEN_W-DATA_W-1:0];
               default: ;
            endcase
         end
         if (cfg_we && (cfg_addr == REG_CTRL)) begin
            irq_en_r <= cfg_wdata[CTRL_IRQ_EN];
         end
         if (done_set_s) begin
            done_r <= 1'b1;
         end else if (done_clr_s) begin
            done_r <= 1'b0;
         end
         if (cfg_re) begin
            cfg_rdata_r <= rd_mux_s;
         end else begin
            cfg_rdata_r <= '0;
         end
      end
   end

endmodule
